// File: rtl/mvd_can_mv_fetch.sv
// Fetches the A/B spatial-neighbour MVs for one inter PU, builds the 2-entry
// AMVP list and returns the lower-cost predictor together with its MVD.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module mvd_can_mv_fetch #(
    parameter int MV_W        = 11,
    parameter int PIC_X_WIDTH = `PIC_X_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [PIC_X_WIDTH-1:0] mb_x_i,
    input  logic [7:0]             a_addr_i,
    input  logic [8:0]             b_addr_i,
    input  logic [MV_W-1:0]        mv_x_i,
    input  logic [MV_W-1:0]        mv_y_i,
    output logic                   cur_rd_o,
    output logic [5:0]             cur_addr_o,
    input  logic [2*MV_W-1:0]      cur_data_i,
    output logic                   left_rd_o,
    output logic [2:0]             left_addr_o,
    input  logic [2*MV_W-1:0]      left_data_i,
    output logic                   top_rd_o,
    output logic [PIC_X_WIDTH+3:0] top_addr_o,
    input  logic [2*MV_W-1:0]      top_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mvp_idx_o,
    output logic [MV_W-1:0]        mvp_x_o,
    output logic [MV_W-1:0]        mvp_y_o,
    output logic [MV_W:0]          mvd_x_o,
    output logic [MV_W:0]          mvd_y_o
);
    localparam logic [1:0] VLD_CUR = 2'b10;
    localparam logic [1:0] VLD_NBR = 2'b01;
    localparam int         CW      = MV_W + 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_CALC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_a_addr;
    logic [8:0]             r_b_addr;
    logic [PIC_X_WIDTH-1:0] r_mb_x;
    logic [MV_W-1:0]        r_mv_x;
    logic [MV_W-1:0]        r_mv_y;
    logic [2*MV_W-1:0]      r_a_mv;
    logic                   r_done;
    logic                   r_idx;
    logic [MV_W-1:0]        r_mvp_x;
    logic [MV_W-1:0]        r_mvp_y;
    logic [MV_W:0]          r_mvd_x;
    logic [MV_W:0]          r_mvd_y;

    logic [1:0]               w_a_vld;
    logic [1:0]               w_b_vld;
    logic                     w_a_av;
    logic                     w_b_av;
    logic                     w_accept;
    logic [PIC_X_WIDTH+3:0]   w_top_addr;
    logic [2*MV_W-1:0]        w_a_mv;
    logic [2*MV_W-1:0]        w_b_mv;
    logic [2*MV_W-1:0]        w_c0;
    logic [2*MV_W-1:0]        w_c1;
    logic [2*MV_W-1:0]        w_mvp;
    logic [CW-1:0]            w_cost0;
    logic [CW-1:0]            w_cost1;
    logic                     w_sel;

    // |p - q| on sign-extended operands; never wraps for MV_W-bit inputs
    function automatic logic [CW-1:0] abs_diff(input logic [MV_W-1:0] p, input logic [MV_W-1:0] q);
        logic [CW-1:0] d;
        d = {{2{p[MV_W-1]}}, p} - {{2{q[MV_W-1]}}, q};
        return d[CW-1] ? ((~d) + {{(CW-1){1'b0}}, 1'b1}) : d;
    endfunction

    function automatic logic [MV_W:0] sub_ext(input logic [MV_W-1:0] p, input logic [MV_W-1:0] q);
        return {p[MV_W-1], p} - {q[MV_W-1], q};
    endfunction

    assign w_a_vld    = r_a_addr[7:6];
    assign w_b_vld    = r_b_addr[8:7];
    assign w_a_av     = (w_a_vld == VLD_CUR) || (w_a_vld == VLD_NBR);
    assign w_b_av     = (w_b_vld == VLD_CUR) || (w_b_vld == VLD_NBR);
    assign w_accept   = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    // x may be 8, which lands on the first column of the next LCU
    assign w_top_addr = {1'b0, r_mb_x, 3'b000} + {{PIC_X_WIDTH{1'b0}}, r_b_addr[3:0]};

    // Moore read strobes and addresses; the current-LCU port serves A then B
    always_comb begin
        cur_rd_o    = 1'b0;
        cur_addr_o  = 6'd0;
        left_rd_o   = 1'b0;
        left_addr_o = 3'd0;
        top_rd_o    = 1'b0;
        top_addr_o  = {(PIC_X_WIDTH+4){1'b0}};
        case (r_state)
            S_FETCH_A: begin
                if (w_a_vld == VLD_CUR) begin
                    cur_rd_o   = 1'b1;
                    cur_addr_o = r_a_addr[5:0];
                end else if (w_a_vld == VLD_NBR) begin
                    left_rd_o   = 1'b1;
                    left_addr_o = r_a_addr[5:3];
                end else begin
                    cur_rd_o = 1'b0;
                end
            end
            S_FETCH_B: begin
                if (w_b_vld == VLD_CUR) begin
                    cur_rd_o   = 1'b1;
                    cur_addr_o = {r_b_addr[6:4], r_b_addr[2:0]};
                end else if (w_b_vld == VLD_NBR) begin
                    top_rd_o   = 1'b1;
                    top_addr_o = w_top_addr;
                end else begin
                    top_rd_o = 1'b0;
                end
            end
            default: cur_rd_o = 1'b0;
        endcase
    end

    // Return-data selection; an unavailable neighbour contributes (0,0)
    always_comb begin
        w_a_mv = {(2*MV_W){1'b0}};
        w_b_mv = {(2*MV_W){1'b0}};
        case (w_a_vld)
            VLD_CUR: w_a_mv = cur_data_i;
            VLD_NBR: w_a_mv = left_data_i;
            default: w_a_mv = {(2*MV_W){1'b0}};
        endcase
        case (w_b_vld)
            VLD_CUR: w_b_mv = cur_data_i;
            VLD_NBR: w_b_mv = top_data_i;
            default: w_b_mv = {(2*MV_W){1'b0}};
        endcase
    end

    // AMVP list, costs and predictor choice (tie keeps index 0)
    always_comb begin
        w_c0 = {(2*MV_W){1'b0}};
        w_c1 = {(2*MV_W){1'b0}};
        if (w_a_av) begin
            w_c0 = r_a_mv;
        end else if (w_b_av) begin
            w_c0 = w_b_mv;
        end else begin
            w_c0 = {(2*MV_W){1'b0}};
        end
        if (w_a_av && w_b_av && (w_b_mv != r_a_mv)) begin
            w_c1 = w_b_mv;
        end else begin
            w_c1 = {(2*MV_W){1'b0}};
        end
        w_cost0 = abs_diff(r_mv_x, w_c0[MV_W-1:0]) + abs_diff(r_mv_y, w_c0[2*MV_W-1:MV_W]);
        w_cost1 = abs_diff(r_mv_x, w_c1[MV_W-1:0]) + abs_diff(r_mv_y, w_c1[2*MV_W-1:MV_W]);
        w_sel   = (w_cost1 < w_cost0);
        w_mvp   = w_sel ? w_c1 : w_c0;
    end

    // Capture the request parameters when a new PU is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a_addr <= 8'd0;
            r_b_addr <= 9'd0;
            r_mb_x   <= {PIC_X_WIDTH{1'b0}};
            r_mv_x   <= {MV_W{1'b0}};
            r_mv_y   <= {MV_W{1'b0}};
        end else if (w_accept) begin
            r_a_addr <= a_addr_i;
            r_b_addr <= b_addr_i;
            r_mb_x   <= mb_x_i;
            r_mv_x   <= mv_x_i;
            r_mv_y   <= mv_y_i;
        end
    end

    // Request sequencer with registered result outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_a_mv  <= {(2*MV_W){1'b0}};
            r_done  <= 1'b0;
            r_idx   <= 1'b0;
            r_mvp_x <= {MV_W{1'b0}};
            r_mvp_y <= {MV_W{1'b0}};
            r_mvd_x <= {(MV_W+1){1'b0}};
            r_mvd_y <= {(MV_W+1){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done  <= 1'b0;
                    r_state <= start_i ? S_FETCH_A : S_IDLE;
                end
                S_FETCH_A: r_state <= S_FETCH_B;
                S_FETCH_B: begin
                    r_a_mv  <= w_a_mv;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_idx   <= w_sel;
                    r_mvp_x <= w_mvp[MV_W-1:0];
                    r_mvp_y <= w_mvp[2*MV_W-1:MV_W];
                    r_mvd_x <= sub_ext(r_mv_x, w_mvp[MV_W-1:0]);
                    r_mvd_y <= sub_ext(r_mv_y, w_mvp[2*MV_W-1:MV_W]);
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= start_i ? S_FETCH_A : S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign mvp_idx_o = r_idx;
    assign mvp_x_o   = r_mvp_x;
    assign mvp_y_o   = r_mvp_y;
    assign mvd_x_o   = r_mvd_x;
    assign mvd_y_o   = r_mvd_y;

endmodule

// File: tb/tb_mvd_can_mv_fetch.sv
// Directed bench for mvd_can_mv_fetch: neighbour memories modelled with
// one-cycle read latency, results compared against hand-computed values.
module tb_mvd_can_mv_fetch;
    localparam int MV_W = 11;
    localparam int PXW  = 8;
    localparam logic [2*MV_W-1:0] POISON = 22'h2AAAAA;

    logic              clk;
    logic              rstn;
    logic              start_i;
    logic [PXW-1:0]    mb_x_i;
    logic [7:0]        a_addr_i;
    logic [8:0]        b_addr_i;
    logic [MV_W-1:0]   mv_x_i;
    logic [MV_W-1:0]   mv_y_i;
    logic              cur_rd_o;
    logic [5:0]        cur_addr_o;
    logic [2*MV_W-1:0] cur_data_i;
    logic              left_rd_o;
    logic [2:0]        left_addr_o;
    logic [2*MV_W-1:0] left_data_i;
    logic              top_rd_o;
    logic [PXW+3:0]    top_addr_o;
    logic [2*MV_W-1:0] top_data_i;
    logic              busy_o;
    logic              done_o;
    logic              mvp_idx_o;
    logic [MV_W-1:0]   mvp_x_o;
    logic [MV_W-1:0]   mvp_y_o;
    logic [MV_W:0]     mvd_x_o;
    logic [MV_W:0]     mvd_y_o;

    logic [2*MV_W-1:0] cur_mem  [64];
    logic [2*MV_W-1:0] left_mem [8];
    logic [2*MV_W-1:0] top_mem  [4096];

    int n_chk   = 0;
    int n_pass  = 0;
    int n_multi = 0;

    mvd_can_mv_fetch #(.MV_W(MV_W), .PIC_X_WIDTH(PXW)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .mb_x_i(mb_x_i),
        .a_addr_i(a_addr_i), .b_addr_i(b_addr_i), .mv_x_i(mv_x_i), .mv_y_i(mv_y_i),
        .cur_rd_o(cur_rd_o), .cur_addr_o(cur_addr_o), .cur_data_i(cur_data_i),
        .left_rd_o(left_rd_o), .left_addr_o(left_addr_o), .left_data_i(left_data_i),
        .top_rd_o(top_rd_o), .top_addr_o(top_addr_o), .top_data_i(top_data_i),
        .busy_o(busy_o), .done_o(done_o), .mvp_idx_o(mvp_idx_o),
        .mvp_x_o(mvp_x_o), .mvp_y_o(mvp_y_o), .mvd_x_o(mvd_x_o), .mvd_y_o(mvd_y_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neighbour memories: data one cycle after the read strobe, garbage otherwise
    always @(posedge clk) begin
        cur_data_i  <= cur_rd_o  ? cur_mem[cur_addr_o]   : POISON;
        left_data_i <= left_rd_o ? left_mem[left_addr_o] : POISON;
        top_data_i  <= top_rd_o  ? top_mem[top_addr_o]   : POISON;
    end

    // Count cycles where more than one read strobe is high
    always @(negedge clk) begin
        if ((cur_rd_o && left_rd_o) || (cur_rd_o && top_rd_o) || (left_rd_o && top_rd_o))
            n_multi <= n_multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      tag, $signed(obs), obs, $signed(exp), exp);
    endtask

    function automatic logic [2*MV_W-1:0] mv_pk(input int x, input int y);
        return {y[MV_W-1:0], x[MV_W-1:0]};
    endfunction

    function automatic int port_addr();
        if (cur_rd_o)       return int'(cur_addr_o);
        else if (left_rd_o) return int'(left_addr_o);
        else if (top_rd_o)  return int'(top_addr_o);
        else                return 0;
    endfunction

    // Issue a one-cycle start, then scramble the inputs; returns in cycle 1
    task automatic start_req(input logic [7:0] a, input logic [8:0] b, input logic [PXW-1:0] mbx,
                             input int mvx, input int mvy);
        @(negedge clk);
        a_addr_i = a;
        b_addr_i = b;
        mb_x_i   = mbx;
        mv_x_i   = mvx[MV_W-1:0];
        mv_y_i   = mvy[MV_W-1:0];
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        a_addr_i = ~a;
        b_addr_i = ~b;
        mb_x_i   = ~mbx;
        mv_x_i   = ~mv_x_i;
        mv_y_i   = ~mv_y_i;
    endtask

    task automatic run_pu(input string tag, input logic [7:0] a, input logic [8:0] b,
                          input logic [PXW-1:0] mbx, input int mvx, input int mvy,
                          input logic [2:0] e_rd1, input int e_ad1,
                          input logic [2:0] e_rd2, input int e_ad2,
                          input int e_idx, input int e_px, input int e_py,
                          input int e_dx, input int e_dy, input bit pulse);
        start_req(a, b, mbx, mvx, mvy);
        chk({tag, ".rd_c1"}, 32'({cur_rd_o, left_rd_o, top_rd_o}), 32'(e_rd1));
        chk({tag, ".addr_c1"}, port_addr(), e_ad1);
        chk({tag, ".busy_c1"}, 32'(busy_o), 32'd1);
        @(negedge clk);
        chk({tag, ".rd_c2"}, 32'({cur_rd_o, left_rd_o, top_rd_o}), 32'(e_rd2));
        chk({tag, ".addr_c2"}, port_addr(), e_ad2);
        if (pulse) begin
            a_addr_i = 8'h00;
            b_addr_i = 9'h000;
            mv_x_i   = 11'd5;
            mv_y_i   = 11'h7FD;
            start_i  = 1'b1;
        end
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, ".rd_c3"}, 32'({cur_rd_o, left_rd_o, top_rd_o}), 32'd0);
        chk({tag, ".done_c3"}, 32'(done_o), 32'd0);
        @(negedge clk);
        chk({tag, ".done_c4"}, 32'(done_o), 32'd1);
        chk({tag, ".busy_c4"}, 32'(busy_o), 32'd1);
        chk({tag, ".idx"}, 32'(mvp_idx_o), 32'(e_idx));
        chk({tag, ".mvp_x"}, 32'($signed(mvp_x_o)), e_px);
        chk({tag, ".mvp_y"}, 32'($signed(mvp_y_o)), e_py);
        chk({tag, ".mvd_x"}, 32'($signed(mvd_x_o)), e_dx);
        chk({tag, ".mvd_y"}, 32'($signed(mvd_y_o)), e_dy);
        @(negedge clk);
        chk({tag, ".done_c5"}, 32'(done_o), 32'd0);
        chk({tag, ".busy_c5"}, 32'(busy_o), 32'd0);
        chk({tag, ".mvd_x_hold"}, 32'($signed(mvd_x_o)), e_dx);
    endtask

    initial begin
        rstn     = 1'b0;
        start_i  = 1'b0;
        mb_x_i   = 8'd0;
        a_addr_i = 8'd0;
        b_addr_i = 9'd0;
        mv_x_i   = 11'd0;
        mv_y_i   = 11'd0;
        for (int i = 0; i < 64; i++) cur_mem[i] = POISON;
        for (int i = 0; i < 8; i++) left_mem[i] = POISON;
        for (int i = 0; i < 4096; i++) top_mem[i] = POISON;
        cur_mem[26]  = mv_pk(4, 4);
        top_mem[24]  = mv_pk(-8, 2);
        cur_mem[10]  = mv_pk(3, 1);
        cur_mem[19]  = mv_pk(3, 1);
        cur_mem[46]  = mv_pk(6, 6);
        left_mem[4]  = mv_pk(1022, 1023);
        top_mem[0]   = mv_pk(1023, 1023);

        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.rd", 32'({cur_rd_o, left_rd_o, top_rd_o}), 32'd0);
        chk("rst.idx", 32'(mvp_idx_o), 32'd0);
        chk("rst.mvd_x", 32'(mvd_x_o), 32'd0);
        rstn = 1'b1;

        //      tag     a      b        mbx   mv          rd1     ad1 rd2     ad2 idx mvp          mvd
        run_pu("none",  8'h00, 9'h000, 8'd0, 5, -3,      3'b000, 0,  3'b000, 0,  0,  0, 0,        5, -3, 1'b0);
        run_pu("a_cur", 8'h9A, 9'h0F8, 8'd2, -7, 2,      3'b100, 26, 3'b001, 24, 1,  -8, 2,       1, 0, 1'b0);
        run_pu("a_eqb", 8'h8A, 9'h123, 8'd0, 3, 1,       3'b100, 10, 3'b100, 19, 0,  3, 1,        0, 0, 1'b0);
        run_pu("b_only",8'h3F, 9'h156, 8'd0, 3, 3,       3'b000, 0,  3'b100, 46, 0,  6, 6,        -3, -3, 1'b0);
        run_pu("ext",   8'h60, 9'h080, 8'd0, -1024, -1024, 3'b010, 4, 3'b001, 0, 0,  1022, 1023, -2046, -2047, 1'b0);
        run_pu("busy",  8'h9A, 9'h0F8, 8'd2, -7, 2,      3'b100, 26, 3'b001, 24, 1,  -8, 2,       1, 0, 1'b1);

        // Abort a request in cycle 3
        start_req(8'h9A, 9'h0F8, 8'd2, 5, 5);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort.busy", 32'(busy_o), 32'd0);
        chk("abort.rd", 32'({cur_rd_o, left_rd_o, top_rd_o}), 32'd0);
        chk("abort.mvp_x", 32'(mvp_x_o), 32'd0);
        chk("abort.mvd_x", 32'(mvd_x_o), 32'd0);
        chk("abort.idx", 32'(mvp_idx_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort.done", 32'(done_o), 32'd0);
        end
        rstn = 1'b1;
        run_pu("post",  8'h8A, 9'h123, 8'd0, 3, 1,       3'b100, 10, 3'b100, 19, 0,  3, 1,        0, 0, 1'b0);

        chk("one_rd_per_cycle", n_multi, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
